// File: rtl/mem_req_arbiter.sv
// Shares one memory port among p_num_clients requesters; in-order tag FIFO routes responses back.
// Zero-latency combinational grant; MEM_REQ_ARBITER_FIXED_PRIO_EN selects fixed priority over round-robin.
module mem_req_arbiter #(
    parameter int p_num_clients  = 2,
    parameter int p_max_inflight = 4,
    parameter int p_req_bits     = 78,
    parameter int p_resp_bits    = 78
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [p_num_clients-1:0]            cli_req_val,
    output logic [p_num_clients-1:0]            cli_req_rdy,
    input  logic [p_num_clients*p_req_bits-1:0] cli_req_msg,
    output logic [p_num_clients-1:0]            cli_resp_val,
    input  logic [p_num_clients-1:0]            cli_resp_rdy,
    output logic [p_resp_bits-1:0]              cli_resp_msg,
    output logic                                mem_req_val,
    input  logic                                mem_req_rdy,
    output logic [p_req_bits-1:0]               mem_req_msg,
    input  logic                                mem_resp_val,
    output logic                                mem_resp_rdy,
    input  logic [p_resp_bits-1:0]              mem_resp_msg
);

    localparam int c_id_bits  = (p_num_clients > 1) ? $clog2(p_num_clients) : 1;
    localparam int c_ptr_bits = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam int c_cnt_bits = $clog2(p_max_inflight + 1);

    logic [c_id_bits-1:0]  tag_q [p_max_inflight];
    logic [c_ptr_bits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cnt_bits-1:0] count_q, count_d;
    logic [c_id_bits-1:0]  win, head, arb_start, idx;
    logic [c_id_bits:0]    sum;
    logic                  any_val, full, empty, grant_ok, req_xfer, resp_xfer;

`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
    assign arb_start = '0;
`else
    logic [c_id_bits-1:0] rr_ptr_q, rr_ptr_d;
    assign arb_start = rr_ptr_q;
`endif

    // Search starts at arb_start and wraps modulo p_num_clients.
    always_comb begin
        any_val = 1'b0;
        win     = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < p_num_clients; k++) begin
            sum = {1'b0, arb_start} + (c_id_bits+1)'(k);
            if (sum >= (c_id_bits+1)'(p_num_clients)) begin
                sum = sum - (c_id_bits+1)'(p_num_clients);
            end
            idx = sum[c_id_bits-1:0];
            if (!any_val && cli_req_val[idx]) begin
                any_val = 1'b1;
                win     = idx;
            end
        end
    end

    assign full      = (count_q == c_cnt_bits'(p_max_inflight));
    assign empty     = (count_q == '0);
    assign grant_ok  = rst & ~full;
    assign mem_req_val = grant_ok & any_val;
    assign req_xfer  = mem_req_val & mem_req_rdy;
    assign head      = tag_q[rd_ptr_q];
    assign mem_resp_rdy = rst & ~empty & cli_resp_rdy[head];
    assign resp_xfer = mem_resp_val & mem_resp_rdy;
    assign cli_resp_msg = mem_resp_msg;

    always_comb begin
        mem_req_msg  = '0;
        cli_req_rdy  = '0;
        cli_resp_val = '0;
        for (int k = 0; k < p_num_clients; k++) begin
            if (c_id_bits'(k) == win) begin
                mem_req_msg    = cli_req_msg[k*p_req_bits +: p_req_bits];
                cli_req_rdy[k] = grant_ok & any_val & mem_req_rdy;
            end
            cli_resp_val[k] = (c_id_bits'(k) == head) & rst & ~empty & mem_resp_val;
        end
    end

    // Pointers wrap naturally because the FIFO depth is a power of two.
    assign wr_ptr_d = req_xfer  ? wr_ptr_q + c_ptr_bits'(1) : wr_ptr_q;
    assign rd_ptr_d = resp_xfer ? rd_ptr_q + c_ptr_bits'(1) : rd_ptr_q;
    assign count_d  = count_q + c_cnt_bits'(req_xfer) - c_cnt_bits'(resp_xfer);

`ifndef MEM_REQ_ARBITER_FIXED_PRIO_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (req_xfer) begin
            rr_ptr_d = (win == c_id_bits'(p_num_clients - 1)) ? '0 : win + c_id_bits'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifndef MEM_REQ_ARBITER_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifndef MEM_REQ_ARBITER_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
            if (req_xfer) begin
                tag_q[wr_ptr_q] <= win;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboarded bench for mem_req_arbiter: queue of expected client IDs in tag-FIFO order.
module tb_mem_req_arbiter;

    localparam int NC = 2;
    localparam int RB = 78;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   cli_req_val, cli_req_rdy, cli_resp_val, cli_resp_rdy;
    logic [NC*RB-1:0] cli_req_msg;
    logic [RB-1:0]   cli_resp_msg, mem_req_msg, mem_resp_msg;
    logic            mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;

    int n_cmp = 0;
    int n_fail = 0;
    int m_rr = 0;
    int sb_q[$];

    mem_req_arbiter #(.p_num_clients(NC), .p_max_inflight(DEPTH), .p_req_bits(RB), .p_resp_bits(RB)) dut (
        .clk(clk), .rst(rst),
        .cli_req_val(cli_req_val), .cli_req_rdy(cli_req_rdy), .cli_req_msg(cli_req_msg),
        .cli_resp_val(cli_resp_val), .cli_resp_rdy(cli_resp_rdy), .cli_resp_msg(cli_resp_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg)
    );

    always #5 clk = ~clk;

    // {op[1:0], opaque[7:0], addr[31:0], strb[3:0], data[31:0]}
    function automatic logic [RB-1:0] mk_msg(input logic [1:0] op, input logic [7:0] opq,
                                             input logic [31:0] addr, input logic [31:0] data);
        return {op, opq, addr, 4'hf, data};
    endfunction

    function automatic logic [RB-1:0] rnd_msg();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[RB-1:0];
    endfunction

    function automatic int pred_win();
        int start;
`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
        start = 0;
`else
        start = m_rr;
`endif
        for (int k = 0; k < NC; k++) begin
            if (cli_req_val[(start + k) % NC]) return (start + k) % NC;
        end
        return -1;
    endfunction

    // Advance the reference model with the inputs currently applied, then clock once.
    task automatic tick();
        int  w;
        bit  grant, pop;
        w     = pred_win();
        grant = rst && (w >= 0) && (sb_q.size() < DEPTH) && mem_req_rdy;
        pop   = rst && (sb_q.size() > 0) && mem_resp_val && cli_resp_rdy[sb_q[0]];
        @(posedge clk);
        if (!rst) begin
            sb_q.delete();
            m_rr = 0;
        end else begin
            if (pop) void'(sb_q.pop_front());
            if (grant) begin
                sb_q.push_back(w);
                m_rr = (w + 1) % NC;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; cli_req_val = '1; mem_req_rdy = 1'b1;
        mem_resp_val = 1'b1; cli_resp_rdy = '1; mem_resp_msg = rnd_msg();
        cli_req_msg = {rnd_msg(), rnd_msg()};
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_val cyc%0d got %b exp 0", i, mem_req_val); end
            n_cmp++; if (cli_req_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_cli_req_rdy cyc%0d got %b exp 00", i, cli_req_rdy); end
            n_cmp++; if (mem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp_rdy cyc%0d got %b exp 0", i, mem_resp_rdy); end
            tick();
        end
        rst = 1'b1; cli_req_val = '0;
        #1;
        n_cmp++; if (mem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL empty_resp_rdy got %b exp 0", mem_resp_rdy); end
        n_cmp++; if (cli_resp_val !== 2'b00) begin n_fail++; $display("FAIL empty_resp_val got %b exp 00", cli_resp_val); end
        tick();
        mem_resp_val = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_id;
        logic [NC-1:0] e;
        cli_req_val = 2'b11; mem_req_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cli_req_msg = {rnd_msg(), rnd_msg()};
            exp_id = i % 2;
            e = 2'b01 << exp_id;
            #1;
            n_cmp++; if (cli_req_rdy !== e) begin n_fail++; $display("FAIL rr_grant%0d got %b exp %b", i, cli_req_rdy, e); end
            n_cmp++; if (mem_req_msg !== cli_req_msg[exp_id*RB +: RB]) begin n_fail++; $display("FAIL rr_msg%0d got %h exp %h", i, mem_req_msg, cli_req_msg[exp_id*RB +: RB]); end
            tick();
        end
        cli_req_val = '0; mem_resp_val = 1'b1; cli_resp_rdy = '1;
        for (int i = 0; i < 4; i++) begin
            mem_resp_msg = rnd_msg();
            exp_id = (sb_q.size() > 0) ? sb_q[0] : 0;
            e = 2'b01 << exp_id;
            #1;
            n_cmp++; if (cli_resp_val !== e) begin n_fail++; $display("FAIL rr_resp_route%0d got %b exp %b", i, cli_resp_val, e); end
            n_cmp++; if (mem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL rr_resp_rdy%0d got %b exp 1", i, mem_resp_rdy); end
            tick();
        end
        mem_resp_val = 1'b0;
    endtask

    task automatic test_routing();
        logic [RB-1:0] m_lw, m_sw, r1, r2;
        m_lw = mk_msg(2'd0, 8'h11, 32'h100, 32'h0);
        m_sw = mk_msg(2'd1, 8'h22, 32'h200, 32'hcafe_f00d);
        cli_req_val = 2'b10; cli_req_msg = {m_lw, rnd_msg()};
        #1;
        n_cmp++; if (cli_req_rdy !== 2'b10) begin n_fail++; $display("FAIL route_grant_lw got %b exp 10", cli_req_rdy); end
        n_cmp++; if (mem_req_msg !== m_lw) begin n_fail++; $display("FAIL route_msg_lw got %h exp %h", mem_req_msg, m_lw); end
        tick();
        cli_req_val = 2'b01; cli_req_msg = {rnd_msg(), m_sw};
        #1;
        n_cmp++; if (cli_req_rdy !== 2'b01) begin n_fail++; $display("FAIL route_grant_sw got %b exp 01", cli_req_rdy); end
        n_cmp++; if (mem_req_msg !== m_sw) begin n_fail++; $display("FAIL route_msg_sw got %h exp %h", mem_req_msg, m_sw); end
        tick();
        cli_req_val = '0; mem_resp_val = 1'b1; cli_resp_rdy = '1;
        r1 = mk_msg(2'd0, 8'h11, 32'h0, 32'h1234_5678);
        r2 = mk_msg(2'd1, 8'h22, 32'h0, 32'h0);
        mem_resp_msg = r1;
        #1;
        n_cmp++; if (cli_resp_val !== 2'b10) begin n_fail++; $display("FAIL route_resp1 got %b exp 10", cli_resp_val); end
        n_cmp++; if (cli_resp_msg !== r1) begin n_fail++; $display("FAIL route_resp1_msg got %h exp %h", cli_resp_msg, r1); end
        tick();
        mem_resp_msg = r2;
        #1;
        n_cmp++; if (cli_resp_val !== 2'b01) begin n_fail++; $display("FAIL route_resp2 got %b exp 01", cli_resp_val); end
        n_cmp++; if (cli_resp_msg !== r2) begin n_fail++; $display("FAIL route_resp2_msg got %h exp %h", cli_resp_msg, r2); end
        tick();
        mem_resp_val = 1'b0;
    endtask

    task automatic test_full();
        int exp_id;
        cli_req_val = 2'b01; mem_req_rdy = 1'b1; cli_req_msg = {rnd_msg(), rnd_msg()};
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_cmp++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got %b exp 1", i, mem_req_val); end
            tick();
        end
        #1;
        n_cmp++; if (cli_req_rdy !== 2'b00) begin n_fail++; $display("FAIL full_rdy got %b exp 00", cli_req_rdy); end
        n_cmp++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL full_val got %b exp 0", mem_req_val); end
        tick();
        mem_resp_val = 1'b1; cli_resp_rdy = '1; mem_resp_msg = rnd_msg();
        #1;
        n_cmp++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle_val got %b exp 0", mem_req_val); end
        n_cmp++; if (mem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_pop_rdy got %b exp 1", mem_resp_rdy); end
        tick();
        mem_resp_val = 1'b0;
        #1;
        n_cmp++; if (cli_req_rdy !== 2'b01) begin n_fail++; $display("FAIL full_regrant got %b exp 01", cli_req_rdy); end
        tick();
        cli_req_val = '0; mem_resp_val = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_id = (sb_q.size() > 0) ? sb_q[0] : -1;
            #1;
            n_cmp++; if (exp_id < 0 || cli_resp_val !== (2'b01 << exp_id)) begin n_fail++; $display("FAIL full_drain%0d got %b exp id %0d", i, cli_resp_val, exp_id); end
            tick();
        end
        mem_resp_val = 1'b0;
        #1;
        n_cmp++; if (mem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL full_drained_rdy got %b exp 0", mem_resp_rdy); end
    endtask

    task automatic test_backpressure();
        cli_req_val = 2'b10; mem_req_rdy = 1'b1; cli_req_msg = {rnd_msg(), rnd_msg()};
        tick();
        cli_req_val = '0; mem_resp_val = 1'b1; cli_resp_rdy = 2'b01; mem_resp_msg = rnd_msg();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (mem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_hold_rdy%0d got %b exp 0", i, mem_resp_rdy); end
            n_cmp++; if (cli_resp_val !== 2'b10) begin n_fail++; $display("FAIL bp_hold_val%0d got %b exp 10", i, cli_resp_val); end
            tick();
        end
        cli_resp_rdy = 2'b11;
        #1;
        n_cmp++; if (mem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got %b exp 1", mem_resp_rdy); end
        tick();
        #1;
        n_cmp++; if (cli_resp_val !== 2'b00 || sb_q.size() != 0) begin n_fail++; $display("FAIL bp_after_pop got %b exp 00", cli_resp_val); end
        mem_resp_val = 1'b0;
    endtask

`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        cli_req_val = 2'b11; mem_req_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cli_req_msg = {rnd_msg(), rnd_msg()};
            #1;
            n_cmp++; if (cli_req_rdy !== 2'b01) begin n_fail++; $display("FAIL fixed_grant%0d got %b exp 01", i, cli_req_rdy); end
            tick();
        end
        cli_req_val = '0; mem_resp_val = 1'b1; cli_resp_rdy = '1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (cli_resp_val !== 2'b01) begin n_fail++; $display("FAIL fixed_resp%0d got %b exp 01", i, cli_resp_val); end
            tick();
        end
        mem_resp_val = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0; cli_req_val = '0; cli_req_msg = '0; cli_resp_rdy = '0;
        mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_msg = '0;
        @(posedge clk); #1;
        test_reset();
`ifdef MEM_REQ_ARBITER_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_routing();
        test_full();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
